// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle requests into WIDTH_CYCLES-wide output
// pulses separated by at least GAP_CYCLES low cycles, queueing up to PEND_MAX.
module pulse_stretcher #(
  parameter int WIDTH_CYCLES = 4,
  parameter int GAP_CYCLES   = 1,
  parameter int PEND_MAX     = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pulse_in,
  input  logic       clr_ovf,
  output logic       stretch_out,
  output logic       stretch_out_not,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [7:0] WIDTH_M1 = 8'(WIDTH_CYCLES - 1);
  localparam logic [7:0] GAP_M1   = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] PEND_LIM = 4'(PEND_MAX);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic       stretch_q, stretch_d;
  logic       launch;
  logic       drop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    stretch_d = stretch_q;
    drop      = 1'b0;
    launch    = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == 8'd0));

    if (launch) begin
      if ((pend_q != 4'd0) || pulse_in) begin
        state_d   = ACTIVE;
        cnt_d     = WIDTH_M1;
        stretch_d = 1'b1;
        // a queued request is consumed; a coincident new pulse takes its slot
        if ((pend_q != 4'd0) && !pulse_in) begin
          pend_d = pend_q - 4'd1;
        end
      end else begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        stretch_d = 1'b0;
      end
    end else begin
      case (state_q)
        ACTIVE: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d   = GAP;
            cnt_d     = GAP_M1;
            stretch_d = 1'b0;
          end
        end
        GAP: cnt_d = cnt_q - 8'd1;
        default: begin
          state_d   = IDLE;
          cnt_d     = 8'd0;
          stretch_d = 1'b0;
        end
      endcase

      if (pulse_in) begin
        if (pend_q < PEND_LIM) begin
          pend_d = pend_q + 4'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      pend_q    <= 4'd0;
      ovf_q     <= 1'b0;
      stretch_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      stretch_q <= stretch_d;
    end
  end

  assign stretch_out     = stretch_q;
  assign stretch_out_not = ~stretch_q;
  assign busy            = (state_q != IDLE) || (pend_q != 4'd0);
  assign pending         = pend_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios then random traffic, checked
// every cycle against a timestamp-based reference model.
module tb_pulse_stretcher;

  localparam int W = 4;
  localparam int G = 1;
  localparam int P = 7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       stretch_out;
  logic       stretch_out_not;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // model: edge index, earliest edge a new pulse may start, start edge of last pulse
  int k = 0;
  int next_launch = 0;
  int last_launch = -1000;
  int m_pend = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .WIDTH_CYCLES(W),
    .GAP_CYCLES  (G),
    .PEND_MAX    (P)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pulse_in       (pulse_in),
    .clr_ovf        (clr_ovf),
    .stretch_out    (stretch_out),
    .stretch_out_not(stretch_out_not),
    .busy           (busy),
    .pending        (pending),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit p, input bit c);
    int exp_st;
    int exp_busy;
    bit drop;
    reset_n  = r;
    pulse_in = p;
    clr_ovf  = c;
    @(posedge clk);
    drop = 1'b0;
    if (!r) begin
      m_pend      = 0;
      m_ovf       = 0;
      last_launch = -1000;
      next_launch = k;
    end else if (k >= next_launch) begin
      if (m_pend > 0 || p) begin
        last_launch = k;
        next_launch = k + W + G;
        if (m_pend > 0 && !p) m_pend--;
      end
    end else if (p) begin
      if (m_pend < P) m_pend++;
      else drop = 1'b1;
    end
    if (r) begin
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
    end
    exp_st   = (k >= last_launch && k <= last_launch + W - 1) ? 1 : 0;
    exp_busy = (m_pend > 0 || k < next_launch) ? 1 : 0;
    #1;
    chk("stretch_out", int'(stretch_out), exp_st);
    chk("stretch_out_not", int'(stretch_out_not), 1 - exp_st);
    chk("busy", int'(busy), exp_busy);
    chk("pending", int'(pending), m_pend);
    chk("overflow", int'(overflow), m_ovf);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // reset, including a pulse that must be ignored
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);

    // single pulse
    tick(1'b1, 1'b1, 1'b0);
    idle(8);

    // back-to-back pulses
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    idle(14);

    // long burst saturates the queue and overflows
    for (int i = 0; i < 14; i++) tick(1'b1, 1'b1, 1'b0);
    // clear coinciding with a drop: set wins
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    idle(60);

    // launch collision: pending=2 with a pulse at the gap launch edge
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    idle(2);
    tick(1'b1, 1'b1, 1'b0);
    idle(25);

    // reset mid-operation with queued requests, then a fresh single pulse
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    tick(1'b1, 1'b1, 1'b0);
    idle(8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) != 0,
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 6);
    end
    idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
